// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared widths, opcode and shifter-mode encodings for the ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [OP_W-1:0] {
        ADD = 4'b0000,
        SUB = 4'b0001,
        AND = 4'b0010,
        OR  = 4'b0011,
        XOR = 4'b0100,
        NOR = 4'b0101,
        SLT = 4'b0110,
        SLL = 4'b0111,
        SRL = 4'b1000,
        SRA = 4'b1001,
        ROL = 4'b1010,
        ROR = 4'b1011,
        MUL = 4'b1100
    } alu_op_e;

    typedef enum logic [2:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_mode_e;

endpackage

`default_nettype wire

// File: rtl/alu_if.sv
// ============================================================================
// Module  : alu_if
// Brief   : Operand/opcode/result bundle between the execute stage and alu_core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_if;
    import alu_pkg::*;

    logic              enable;
    logic [OP_W-1:0]   OP;
    word_t             src1;
    word_t             src2;
    word_t             alu_result;
    logic              Overflow;

    modport master (
        output enable, OP, src1, src2,
        input  alu_result, Overflow
    );

    modport slave (
        input  enable, OP, src1, src2,
        output alu_result, Overflow
    );
endinterface

`default_nettype wire

// File: rtl/alu_shifter.sv
// ============================================================================
// Module  : alu_shifter
// Brief   : Combinational 32-bit barrel shifter/rotator (SLL/SRL/SRA/ROL/ROR).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shifter
    import alu_pkg::*;
(
    input  word_t       data,
    input  logic [4:0]  amount,
    input  shift_mode_e mode,
    output word_t       result
);

    // Complementary shift for rotates; amount 0 gives 32, which shifts to zero.
    logic [5:0] inv_amount;
    assign inv_amount = 6'd32 - {1'b0, amount};

    always_comb begin
        result = data;
        case (mode)
            SH_SLL:  result = data << amount;
            SH_SRL:  result = data >> amount;
            SH_SRA:  result = word_t'($signed(data) >>> amount);
            SH_ROL:  result = (data << amount) | (data >> inv_amount);
            SH_ROR:  result = (data >> amount) | (data << inv_amount);
            default: result = data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module  : alu_core
// Brief   : 32-bit integer ALU, registered result and signed-overflow flag.
//           Optional macro ALU_MUL_EN enables the MUL opcode (4'b1100).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    alu_if.slave       bus
);

    word_t       a;
    word_t       b;
    word_t       sum;
    word_t       diff;
    word_t       shift_out;
    shift_mode_e shift_mode;
    word_t       next_result;
    logic        next_ov;
    word_t       result_q;
    logic        ov_q;

    assign a    = bus.src1;
    assign b    = bus.src2;
    assign sum  = a + b;
    assign diff = a - b;

`ifdef ALU_MUL_EN
    logic signed [2*DATA_W-1:0] prod;
    assign prod = $signed(a) * $signed(b);
`endif

    // Kept separate from the result mux so the shifter feeds forward only.
    always_comb begin
        shift_mode = SH_SLL;
        case (bus.OP)
            SRL:     shift_mode = SH_SRL;
            SRA:     shift_mode = SH_SRA;
            ROL:     shift_mode = SH_ROL;
            ROR:     shift_mode = SH_ROR;
            default: shift_mode = SH_SLL;
        endcase
    end

    alu_shifter u_shifter (
        .data   (a),
        .amount (b[4:0]),
        .mode   (shift_mode),
        .result (shift_out)
    );

    always_comb begin
        next_result = '0;
        next_ov     = 1'b0;
        case (bus.OP)
            ADD: begin
                next_result = sum;
                next_ov     = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            SUB: begin
                next_result = diff;
                next_ov     = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            AND: next_result = a & b;
            OR:  next_result = a | b;
            XOR: next_result = a ^ b;
            NOR: next_result = ~(a | b);
            SLT: next_result = {31'd0, ($signed(a) < $signed(b))};
            SLL, SRL, SRA, ROL, ROR: next_result = shift_out;
`ifdef ALU_MUL_EN
            MUL: begin
                next_result = prod[DATA_W-1:0];
                next_ov     = (prod[2*DATA_W-1:DATA_W] != {DATA_W{prod[DATA_W-1]}});
            end
`endif
            default: begin
                next_result = '0;
                next_ov     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            ov_q     <= 1'b0;
        end else if (bus.enable) begin
            result_q <= next_result;
            ov_q     <= next_ov;
        end
    end

    assign bus.alu_result = result_q;
    assign bus.Overflow   = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// ============================================================================
// Module  : tb_alu_core
// Brief   : Directed self-checking bench for alu_core (honours ALU_MUL_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_if bus ();

    alu_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Present inputs, let one edge pass, then sample 1 time unit later.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic en);
        bus.OP     = op;
        bus.src1   = a;
        bus.src2   = b;
        bus.enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b0000, 32'd5, 32'd5, 1'b1);
        drive(4'b0000, 32'd5, 32'd5, 1'b1);
        n_cmp++;
        if (bus.alu_result !== 32'd0 || bus.Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got %h/%b expected 00000000/0", bus.alu_result, bus.Overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [3:0]  op [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0001, 4'b0001, 4'b0001, 4'b0001};
        logic [31:0] a  [8] = '{32'h3, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                32'hE, 32'h80000000, 32'h7FFFFFFF, 32'h5};
        logic [31:0] b  [8] = '{32'h9, 32'h1, 32'h1, 32'h80000000,
                                32'h7, 32'h1, 32'hFFFFFFFF, 32'h5};
        logic [31:0] er [8] = '{32'h0000000C, 32'h80000000, 32'h00000000, 32'h00000000,
                                32'h00000007, 32'h7FFFFFFF, 32'h80000000, 32'h00000000};
        logic        eo [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(op[i], a[i], b[i], 1'b1);
            n_cmp++;
            if (bus.alu_result !== er[i] || bus.Overflow !== eo[i]) begin
                n_err++;
                $display("FAIL arith[%0d] op=%b %h,%h: got %h/%b expected %h/%b",
                         i, op[i], a[i], b[i], bus.alu_result, bus.Overflow, er[i], eo[i]);
            end
        end
    endtask

    task automatic test_logic_slt();
        logic [3:0]  op [8] = '{4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                4'b0110, 4'b0110, 4'b0110, 4'b0110};
        logic [31:0] a  [8] = '{32'hCC, 32'hCC, 32'hCC, 32'hCC,
                                32'h5, 32'hFFFFFFFE, 32'h2, 32'h80000000};
        logic [31:0] b  [8] = '{32'hAA, 32'hAA, 32'hAA, 32'hAA,
                                32'h2, 32'h2, 32'hFFFFFFFE, 32'h7FFFFFFF};
        logic [31:0] er [8] = '{32'h88, 32'hEE, 32'h66, 32'hFFFFFF11,
                                32'h0, 32'h1, 32'h0, 32'h1};
        for (int i = 0; i < 8; i++) begin
            drive(op[i], a[i], b[i], 1'b1);
            n_cmp++;
            if (bus.alu_result !== er[i] || bus.Overflow !== 1'b0) begin
                n_err++;
                $display("FAIL logic_slt[%0d] op=%b: got %h/%b expected %h/0",
                         i, op[i], bus.alu_result, bus.Overflow, er[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [3:0]  op [9] = '{4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                                4'b0111, 4'b1011, 4'b1010, 4'b1001};
        logic [31:0] a  [9] = '{32'h1, 32'h80000000, 32'h80000000, 32'h80000001, 32'h1,
                                32'h1, 32'h12345678, 32'h1, 32'h40000000};
        logic [31:0] b  [9] = '{32'h1, 32'h4, 32'h4, 32'h1, 32'h1,
                                32'h21, 32'h0, 32'h1F, 32'h4};
        logic [31:0] er [9] = '{32'h2, 32'h08000000, 32'hF8000000, 32'h3, 32'h80000000,
                                32'h2, 32'h12345678, 32'h80000000, 32'h04000000};
        for (int i = 0; i < 9; i++) begin
            drive(op[i], a[i], b[i], 1'b1);
            n_cmp++;
            if (bus.alu_result !== er[i] || bus.Overflow !== 1'b0) begin
                n_err++;
                $display("FAIL shift[%0d] op=%b %h,%h: got %h/%b expected %h/0",
                         i, op[i], a[i], b[i], bus.alu_result, bus.Overflow, er[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive(4'b0000, 32'h1, 32'h1, 1'b1);
        n_cmp++;
        if (bus.alu_result !== 32'h2) begin
            n_err++;
            $display("FAIL hold_load: got %h expected 00000002", bus.alu_result);
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, 32'h80000000 + i, 32'h1, 1'b0);
            n_cmp++;
            if (bus.alu_result !== 32'h2 || bus.Overflow !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: got %h/%b expected 00000002/0",
                         i, bus.alu_result, bus.Overflow);
            end
        end
        // Reset must win over a pending enable.
        drive(4'b0000, 32'h7FFFFFFF, 32'h1, 1'b1);
        rst = 1'b1;
        drive(4'b0000, 32'h7FFFFFFF, 32'h1, 1'b1);
        rst = 1'b0;
        n_cmp++;
        if (bus.alu_result !== 32'h0 || bus.Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_priority: got %h/%b expected 00000000/0",
                     bus.alu_result, bus.Overflow);
        end
    endtask

    task automatic test_reserved();
        logic [3:0] op [3] = '{4'b1101, 4'b1110, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 32'h7FFFFFFF, 32'h1, 1'b1);
            drive(op[i], 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1);
            n_cmp++;
            if (bus.alu_result !== 32'h0 || bus.Overflow !== 1'b0) begin
                n_err++;
                $display("FAIL reserved op=%b: got %h/%b expected 00000000/0",
                         op[i], bus.alu_result, bus.Overflow);
            end
        end
    endtask

    task automatic test_mul();
`ifdef ALU_MUL_EN
        drive(4'b1100, 32'h7FFFFFFF, 32'h2, 1'b1);
        n_cmp++;
        if (bus.alu_result !== 32'hFFFFFFFE || bus.Overflow !== 1'b1) begin
            n_err++;
            $display("FAIL mul_ovf: got %h/%b expected FFFFFFFE/1", bus.alu_result, bus.Overflow);
        end
        drive(4'b1100, 32'h3, 32'hFFFFFFFE, 1'b1);
        n_cmp++;
        if (bus.alu_result !== 32'hFFFFFFFA || bus.Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL mul_neg: got %h/%b expected FFFFFFFA/0", bus.alu_result, bus.Overflow);
        end
`else
        drive(4'b0000, 32'h1, 32'h1, 1'b1);
        drive(4'b1100, 32'h7FFFFFFF, 32'h2, 1'b1);
        n_cmp++;
        if (bus.alu_result !== 32'h0 || bus.Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL mul_reserved: got %h/%b expected 00000000/0",
                     bus.alu_result, bus.Overflow);
        end
`endif
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.OP     = 4'b0000;
        bus.src1   = '0;
        bus.src2   = '0;
        test_reset();
        test_arith();
        test_logic_slt();
        test_shift();
        test_hold();
        test_reserved();
        test_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
